// File: rtl/countdown_timer_if.sv
// Load handshake, run control and status of the countdown timer.
// The master drives loads and control; the slave is the timer itself.
interface countdown_timer_if #(
    parameter int unsigned BW = 8
);
    logic          load_valid_i;
    logic [BW-1:0] load_value_i;
    logic          load_ready_o;
    logic          start_i;
    logic          stop_i;
    logic          autoreload_i;
    logic [BW-1:0] count_o;
    logic          busy_o;
    logic          done_o;

    modport master (
        output load_valid_i,
        output load_value_i,
        input  load_ready_o,
        output start_i,
        output stop_i,
        output autoreload_i,
        input  count_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  load_valid_i,
        input  load_value_i,
        output load_ready_o,
        input  start_i,
        input  stop_i,
        input  autoreload_i,
        output count_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/resume, one-cycle expiry pulse and periodic reload.
// Holds a start value in a reload register so autoreload restarts the same period.
module countdown_timer #(
    parameter int unsigned BW = 8
) (
    input logic              clk_i,
    input logic              nrst_i,
    input logic              nrstSync_i,
    countdown_timer_if.slave tmr
);
    typedef enum logic [1:0] {StIdle, StArmed, StRun, StPaused} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] count_q, count_d;
    logic [BW-1:0] reload_q, reload_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          load_ready;

    assign load_ready = (state_q != StRun);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (!nrstSync_i) begin
            state_d  = StIdle;
            count_d  = '0;
            reload_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StArmed, StPaused: begin
                    // A load wins over start on the same edge.
                    if (tmr.load_valid_i) begin
                        count_d  = tmr.load_value_i;
                        reload_d = tmr.load_value_i;
                        state_d  = (tmr.load_value_i != '0) ? StArmed : StIdle;
                    end else if (tmr.start_i && state_q != StIdle) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (tmr.stop_i) begin
                        state_d = StPaused;
                    end else if (count_q > BW'(1)) begin
                        count_d = count_q - BW'(1);
                    end else if (count_q == BW'(1)) begin
                        done_d = 1'b1;
                        if (tmr.autoreload_i) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = StIdle;
                        end
                    end else begin
                        // Unreachable in normal operation; recover quietly.
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign tmr.load_ready_o = load_ready;
    assign tmr.count_o      = count_q;
    assign tmr.busy_o       = busy_q;
    assign tmr.done_o       = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random stimulus
// compared every cycle against a behavioural model of the timer.
module tb_countdown_timer;
    localparam int unsigned BW = 8;

    logic clk_i;
    logic nrst_i;
    logic nrstSync_i;

    countdown_timer_if #(.BW(BW)) bus ();

    countdown_timer #(.BW(BW)) dut (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .nrstSync_i (nrstSync_i),
        .tmr        (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a timer is either running or not; a stopped timer with a
    // nonzero count can be started, a zero count cannot.
    int unsigned m_count  = 0;
    int unsigned m_reload = 0;
    bit          m_run    = 1'b0;
    bit          m_done   = 1'b0;
    int          done_seen = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_reload = 0;
        m_run    = 1'b0;
        m_done   = 1'b0;
    endtask

    task automatic model_edge(input bit lv, input int unsigned lval, input bit st,
                              input bit sp, input bit ar, input bit sync_n);
        m_done = 1'b0;
        if (!sync_n) begin
            model_reset();
        end else if (!m_run) begin
            if (lv) begin
                m_count  = lval;
                m_reload = lval;
            end else if (st && m_count != 0) begin
                m_run = 1'b1;
            end
        end else if (sp) begin
            m_run = 1'b0;
        end else if (m_count > 1) begin
            m_count = m_count - 1;
        end else begin
            m_done = 1'b1;
            if (ar) begin
                m_count = m_reload;
            end else begin
                m_count = 0;
                m_run   = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        check("count", int'(bus.count_o), m_count);
        check("busy", int'(bus.busy_o), int'(m_run));
        check("done", int'(bus.done_o), int'(m_done));
        check("ready", int'(bus.load_ready_o), int'(!m_run));
        if (bus.done_o === 1'b1) done_seen++;
    endtask

    task automatic step(input bit lv, input int unsigned lval, input bit st,
                        input bit sp, input bit ar, input bit sync_n);
        bus.load_valid_i = lv;
        bus.load_value_i = BW'(lval);
        bus.start_i      = st;
        bus.stop_i       = sp;
        bus.autoreload_i = ar;
        nrstSync_i       = sync_n;
        @(posedge clk_i);
        model_edge(lv, lval, st, sp, ar, sync_n);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit ar);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, ar, 1'b1);
    endtask

    // Called just after an edge: pulse nrst_i between edges and check at once.
    task automatic async_reset_pulse();
        #2 nrst_i = 1'b0;
        #1;
        model_reset();
        check("async_count", int'(bus.count_o), 0);
        check("async_busy", int'(bus.busy_o), 0);
        check("async_done", int'(bus.done_o), 0);
        check("async_ready", int'(bus.load_ready_o), 1);
        #1 nrst_i = 1'b1;
    endtask

    initial begin
        bus.load_valid_i = 1'b0;
        bus.load_value_i = '0;
        bus.start_i      = 1'b0;
        bus.stop_i       = 1'b0;
        bus.autoreload_i = 1'b0;
        nrstSync_i       = 1'b1;
        nrst_i           = 1'b0;
        #1;
        check("reset_count", int'(bus.count_o), 0);
        check("reset_busy", int'(bus.busy_o), 0);
        check("reset_done", int'(bus.done_o), 0);
        check("reset_ready", int'(bus.load_ready_o), 1);
        #2 nrst_i = 1'b1;

        // One-shot: load 5, start, expect 4..0 and a single done pulse.
        step(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("oneshot_start_count", int'(bus.count_o), 5);
        done_seen = 0;
        for (int k = 4; k >= 0; k--) begin
            step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("oneshot_seq", int'(bus.count_o), k);
        end
        check("oneshot_done_at_zero", int'(bus.done_o), 1);
        idle(4, 1'b0);
        check("oneshot_pulses", done_seen, 1);

        // Autoreload with N=3: pulses every 3 cycles, busy stays high.
        step(1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        done_seen = 0;
        idle(12, 1'b1);
        check("autoreload_pulses", done_seen, 4);
        check("autoreload_busy", int'(bus.busy_o), 1);
        idle(2, 1'b0);
        idle(2, 1'b0);

        // Pause/resume: load 10, 4 decrements, stop, hold, resume.
        step(1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b0);
        check("pause_hold", int'(bus.count_o), 6);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        done_seen = 0;
        idle(6, 1'b0);
        check("resume_done", int'(bus.done_o), 1);

        // Load during RUN is refused.
        step(1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 200, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 200, 1'b0, 1'b0, 1'b0, 1'b1);
        check("run_load_ignored", int'(bus.count_o), 18);
        idle(20, 1'b0);

        // Zero load never runs or expires.
        done_seen = 0;
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(5, 1'b0);
        check("zero_busy", int'(bus.busy_o), 0);
        check("zero_pulses", done_seen, 0);

        // Async reset at count 5.
        step(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        check("pre_async_count", int'(bus.count_o), 5);
        done_seen = 0;
        async_reset_pulse();
        idle(10, 1'b0);
        check("async_no_done", done_seen, 0);

        // Sync reset at count 5.
        step(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        done_seen = 0;
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sync_count", int'(bus.count_o), 0);
        idle(10, 1'b0);
        check("sync_no_done", done_seen, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          lv;
            int unsigned lval;
            lv   = ($urandom_range(0, 7) == 0);
            lval = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << BW) - 1)
                                               : $urandom_range(0, 12);
            step(lv, lval, ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) != 0));
            if ($urandom_range(0, 299) == 0) async_reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter BW, default 8, giving the counter width in bits.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port nrst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port nrstSync_i, input, 1 bit: synchronous clear, active-low, sampled on the rising edge.
REQ-005 SHALL have port load_valid_i, input, 1 bit: a load value is offered.
REQ-006 SHALL have port load_value_i, input, BW bits: the countdown start value N.
REQ-007 SHALL have port load_ready_o, output, 1 bit: the timer can accept a load.
REQ-008 SHALL have port start_i, input, 1 bit: start or resume counting.
REQ-009 SHALL have port stop_i, input, 1 bit: pause counting.
REQ-010 SHALL have port autoreload_i, input, 1 bit: periodic mode; sampled only at expiry.
REQ-011 SHALL have port count_o, output, BW bits: the current count value.
REQ-012 SHALL have port busy_o, output, 1 bit: the state is RUN.
REQ-013 SHALL have port done_o, output, 1 bit: a one-cycle expiry pulse.

Function
REQ-014 SHALL implement the states IDLE, ARMED, RUN and PAUSED, plus a BW-bit count register and a BW-bit reload register.
REQ-015 SHALL drive load_ready_o = 1 in IDLE, ARMED and PAUSED, and 0 in RUN; load_ready_o is decoded from state only.
REQ-016 SHALL accept a load on an edge where load_valid_i and load_ready_o are both 1; on acceptance: count and reload both take load_value_i.
  - If load_value_i is nonzero: next state is ARMED.
  - If load_value_i is 0: next state is IDLE and count is 0.
REQ-017 SHALL give a load priority over start_i on the same edge; start_i is ignored on that edge.
REQ-018 SHALL, for start_i = 1 in ARMED or PAUSED with no load on that edge: enter RUN on that edge; count is not decremented on that edge.
REQ-019 SHALL ignore start_i in IDLE and in RUN.
REQ-020 SHALL, in RUN with stop_i = 1: enter PAUSED and hold count; stop_i has priority over decrement and expiry on that edge.
REQ-021 SHALL ignore stop_i outside RUN.
REQ-022 SHALL, in RUN with count > 1: decrement count by 1 per edge (count - 1 at BW bits, no wrap possible).
REQ-023 SHALL, in RUN with count == 1, set done_o = 1 for the next cycle only, and:
  - if autoreload_i = 1: count takes the reload value and the state stays RUN;
  - if autoreload_i = 0: count becomes 0 and the state becomes IDLE.
REQ-024 SHALL have the following timing: with N loaded and start sampled at edge t, count equals N-k after edge t+k, and done_o is high after edge t+N.
REQ-025 SHALL give an autoreload period of exactly N cycles between done_o pulses.
REQ-026 SHALL register done_o and busy_o, and SHALL drive count_o directly from the count register.
REQ-027 SHALL keep done_o 0 in every cycle other than the expiry cycle.

Reset
REQ-028 SHALL, when nrst_i = 0, immediately (asynchronously) set:
  - state to IDLE;
  - count, reload, count_o, done_o and busy_o to 0;
  - load_ready_o to 1.
REQ-029 SHALL, when nrstSync_i = 0 at an edge, apply the same values as REQ-028 at that edge; this has priority over all other inputs.
REQ-030 SHALL let a reset in any state, including mid-RUN, abort the countdown with no done_o pulse.

Verification
REQ-031 SHALL cover one-shot: BW=8, load 5, start.
  - Required: count 4,3,2,1,0 on the following edges; done_o=1 for exactly one cycle with count_o=0; then busy_o=0 and load_ready_o=1.
REQ-032 SHALL cover autoreload: load 3, autoreload_i=1, start.
  - Required: count 2,1,3,2,1,3...; done_o pulses every 3 cycles; busy_o stays 1.
REQ-033 SHALL cover pause/resume: load 10, start, assert stop_i after 4 decrements.
  - Required: count holds 6 for 3 cycles.
  - After start_i: 5,4,...; done_o occurs 6 edges after resume.
REQ-034 SHALL cover load during RUN: load_valid_i=1 with value 200 during RUN.
  - Required: load_ready_o=0, the value is not accepted, and the countdown is unaffected.
REQ-035 SHALL cover a zero load: load 0, then start_i.
  - Required: the state stays IDLE, count_o=0, busy_o=0, and there is never a done_o.
REQ-036 SHALL cover reset mid-run: load 8 and start; drop nrst_i at count 5, then drop nrstSync_i in a separate run at count 5.
  - nrst_i case: outputs are 0 immediately.
  - nrstSync_i case: outputs are 0 after the next edge.
  - Both cases: no done_o.
